mem_responder: RTL and testbench

Memory-side responder for the Mini-SRC datapath memory interface. It accepts Read/Write strobes with the MAR address and MDR write data, services them from an internal word-addressed RAM after a programmable number of wait states, and returns read data on `Mdatain` with a one-cycle memory-function-complete (`MFC`) pulse. It sits between the datapath's MAR/MDR and main memory, and replaces bench-driven `Mdatain` stimulus with a real memory that follows the handshake.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the Mini-SRC MAR/MDR interface.
// Accepts a 4-phase Read/Write request, services it from an internal
// word-addressed RAM after WAIT_CYCLES wait states, pulses MFC for one
// cycle, then holds busy until the requester drops its strobes.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] MAR_addr,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] MDR_data,
  output logic [31:0] Mdatain,
  output logic        MFC,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // WAIT_CYCLES of 0 skips the WAIT state entirely, so the load value is moot.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              is_read_q;
  logic              is_write_q;
  logic              conflict_q;
  logic              range_fault_q;

  logic [31:0] ram [2**ADDR_W];

  logic range_fault;
  logic conflict;
  logic do_write;

  // Any set bit above the RAM index field makes the address unreachable.
  assign range_fault = (MAR_addr >> ADDR_W) != 32'd0;
  assign conflict    = Read & Write;

  // The RAM update happens on the edge that leaves DONE, together with MFC.
  // A faulted or conflicting request never touches the array, and clear on
  // that edge also blocks it.
  assign do_write = (state == DONE) && is_write_q && !conflict_q &&
                    !range_fault_q && !clear;

  // RAM storage: not reset, contents only change through a good write.
  always_ff @(posedge clock) begin
    if (do_write) begin
      ram[addr_q] <= data_q;
    end
  end

  // Handshake FSM: accept in IDLE, count wait states, complete in DONE and
  // wait in RELEASE for the strobes to drop so a held strobe cannot retrigger.
  always_ff @(posedge clock) begin
    if (clear) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      Mdatain       <= 32'd0;
      MFC           <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      addr_q        <= '0;
      data_q        <= 32'd0;
      is_read_q     <= 1'b0;
      is_write_q    <= 1'b0;
      conflict_q    <= 1'b0;
      range_fault_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Read || Write) begin
            addr_q        <= MAR_addr[ADDR_W-1:0];
            data_q        <= MDR_data;
            is_read_q     <= Read;
            is_write_q    <= Write;
            conflict_q    <= conflict;
            range_fault_q <= range_fault;
            err           <= conflict | range_fault;
            busy          <= 1'b1;
            wait_cnt      <= WAIT_LOAD;
            state         <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          MFC <= 1'b1;
          // A Read+Write conflict leaves Mdatain untouched; an out-of-range
          // read returns zero so stale data never looks like a valid result.
          if (is_read_q && !conflict_q) begin
            Mdatain <= range_fault_q ? 32'd0 : ram[addr_q];
          end
          state <= RELEASE;
        end
        RELEASE: begin
          MFC <= 1'b0;
          if (!Read && !Write) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. Two instances share
// the stimulus bus: dutA with WAIT_CYCLES=2 and dutB with WAIT_CYCLES=0;
// 'sel' routes strobes and observed outputs to one of them.
module tb_mem_responder;

  localparam int AW = 9;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        Read;
  logic        Write;
  logic        sel;
  logic [31:0] MAR_addr;
  logic [31:0] MDR_data;

  logic [31:0] mdA, mdB;
  logic        mfcA, mfcB, busyA, busyB, errA, errB;
  logic [31:0] mdObs;
  logic        mfcObs, busyObs, errObs;

  int total = 0;
  int bad = 0;
  int mfcCount = 0;

  exp_t        scoreQ[$];
  logic [31:0] model[2][512];
  logic [31:0] lastData[2];

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dutA (
    .clock(clock), .clear(clear), .MAR_addr(MAR_addr),
    .Read(Read & ~sel), .Write(Write & ~sel), .MDR_data(MDR_data),
    .Mdatain(mdA), .MFC(mfcA), .busy(busyA), .err(errA)
  );

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dutB (
    .clock(clock), .clear(clear), .MAR_addr(MAR_addr),
    .Read(Read & sel), .Write(Write & sel), .MDR_data(MDR_data),
    .Mdatain(mdB), .MFC(mfcB), .busy(busyB), .err(errB)
  );

  assign mdObs   = sel ? mdB   : mdA;
  assign mfcObs  = sel ? mfcB  : mfcA;
  assign busyObs = sel ? busyB : busyA;
  assign errObs  = sel ? errB  : errA;

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  // Scoreboard consumer: every MFC pulse pops one expected completion.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (mfcObs === 1'b1) begin
      mfcCount++;
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_mfc", 32'd1, 32'd0);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("mdatain", mdObs, e.data);
        checkOutput("err", {31'd0, errObs}, {31'd0, e.err});
      end
    end
  end

  // One full 4-phase transaction on the selected instance. The expected
  // completion is derived from the bench's own memory model and queued.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int hold);
    logic [31:0] expData;
    logic        expErr;
    int          lat;
    int          pulses0;
    int          s;
    s = sel ? 1 : 0;
    expData = lastData[s];
    expErr  = 1'b0;
    if (rd && wr) begin
      expErr = 1'b1;
    end else if ((addr >> AW) != 32'd0) begin
      expErr = 1'b1;
      if (rd) begin
        expData = 32'd0;
        lastData[s] = 32'd0;
      end
    end else if (rd) begin
      expData = model[s][addr[AW-1:0]];
      lastData[s] = expData;
    end else begin
      model[s][addr[AW-1:0]] = data;
    end
    pulses0 = mfcCount;

    @(negedge clock);
    MAR_addr = addr;
    MDR_data = data;
    Read     = rd;
    Write    = wr;
    scoreQ.push_back('{data: expData, err: expErr});

    @(posedge clock);
    #1;
    checkOutput("busy_after_accept", {31'd0, busyObs}, 32'd1);
    // Bus changes after acceptance must not leak into the access.
    MAR_addr = ~addr;
    MDR_data = ~data;

    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!mfcObs && lat < 20);
    checkOutput("mfc_latency", 32'(lat), sel ? 32'd1 : 32'd3);

    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      checkOutput("busy_held", {31'd0, busyObs}, 32'd1);
      checkOutput("mfc_low_held", {31'd0, mfcObs}, 32'd0);
    end

    @(negedge clock);
    Read  = 1'b0;
    Write = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("busy_release", {31'd0, busyObs}, 32'd0);
    checkOutput("mfc_pulses", 32'(mfcCount - pulses0), 32'd1);
  endtask

  // Guard against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int pulsesBefore;
    clear    = 1'b1;
    Read     = 1'b0;
    Write    = 1'b0;
    sel      = 1'b0;
    MAR_addr = 32'd0;
    MDR_data = 32'd0;
    lastData[0] = 32'd0;
    lastData[1] = 32'd0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_mdatain_a", mdObs, 32'd0);
    checkOutput("rst_mfc_a", {31'd0, mfcObs}, 32'd0);
    checkOutput("rst_busy_a", {31'd0, busyObs}, 32'd0);
    checkOutput("rst_err_a", {31'd0, errObs}, 32'd0);
    sel = 1'b1;
    #1;
    checkOutput("rst_mdatain_b", mdObs, 32'd0);
    checkOutput("rst_busy_b", {31'd0, busyObs}, 32'd0);
    sel = 1'b0;
    @(negedge clock);
    clear = 1'b0;

    // Write then read back, plus preload of the locations used later.
    applyStimulus(1'b0, 1'b1, 32'd2, 32'h0000_0022, 0);
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd0, 0);
    applyStimulus(1'b0, 1'b1, 32'd4, 32'h0000_0024, 0);
    applyStimulus(1'b0, 1'b1, 32'd6, 32'h0000_0026, 0);
    applyStimulus(1'b0, 1'b1, 32'd8, 32'h1111_1111, 0);

    // Read strobe held for 10 cycles after completion.
    applyStimulus(1'b1, 1'b0, 32'd4, 32'd0, 10);

    // Out-of-range read and write.
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'd0, 0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0202, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd0, 0);

    // Read and Write together.
    applyStimulus(1'b1, 1'b1, 32'd6, 32'h0000_0099, 0);
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd0, 0);

    // Reset one cycle into a write's wait period.
    pulsesBefore = mfcCount;
    @(negedge clock);
    MAR_addr = 32'd8;
    MDR_data = 32'h7A28_0000;
    Write    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("abort_mdatain", mdObs, 32'd0);
    checkOutput("abort_mfc", {31'd0, mfcObs}, 32'd0);
    checkOutput("abort_busy", {31'd0, busyObs}, 32'd0);
    checkOutput("abort_err", {31'd0, errObs}, 32'd0);
    @(negedge clock);
    clear = 1'b0;
    Write = 1'b0;
    lastData[0] = 32'd0;
    lastData[1] = 32'd0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("abort_no_mfc", 32'(mfcCount - pulsesBefore), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd8, 32'd0, 0);

    // Zero wait states: preload, then alternate reads with one idle cycle.
    sel = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'd2, 32'h0000_0022, 0);
    applyStimulus(1'b0, 1'b1, 32'd4, 32'h0000_0024, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 32'd2 : 32'd4, 32'd0, 0);
    end

    repeat (3) @(posedge clock);
    checkOutput("queue_empty", 32'(scoreQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
